// File: rtl/dual_port_ram_p_if.sv
// Bus bundle for dual_port_ram_p: two independent access ports plus status flags.
// The master drives the requests; the RAM (slave) returns read data and status.
interface dual_port_ram_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              en_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] q_a;
  logic              valid_a;

  logic              en_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] q_b;
  logic              valid_b;

  logic              init_busy;
  logic              collision;

  modport master (
    output en_a, we_a, addr_a, data_a,
    output en_b, we_b, addr_b, data_b,
    input  q_a, valid_a, q_b, valid_b,
    input  init_busy, collision
  );

  modport slave (
    input  en_a, we_a, addr_a, data_a,
    input  en_b, we_b, addr_b, data_b,
    output q_a, valid_a, q_b, valid_b,
    output init_busy, collision
  );
endinterface

// File: rtl/dual_port_ram_p.sv
// True dual-port RAM with a power-up clear sequence, selectable read-during-write
// behaviour, optional output pipeline stage and same-address write collision flag.
module dual_port_ram_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input logic               clk,
  input logic               rst_n,
  dual_port_ram_p_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              acc_a, acc_b;
  logic              wr_a, wr_b;
  logic              init_wr;
  logic [DATA_W-1:0] rd_a, rd_b;

  logic [DATA_W-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d;
  logic              v1_a_q, v1_b_q;
  logic              coll_q, coll_d;

  assign run     = (state_q == ST_RUN);
  assign acc_a   = run && bus.en_a;
  assign acc_b   = run && bus.en_b;
  assign wr_a    = acc_a && bus.we_a;
  assign wr_b    = acc_b && bus.we_b;
  // Clearing is held off while reset is asserted so contents only change after release.
  assign init_wr = (state_q == ST_INIT) && rst_n;

  // Clear pointer stops at the last word instead of wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      if (ptr_q == '1) begin
        state_d = ST_RUN;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Port A is written last so its data wins a same-address dual write.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[ptr_q] <= '0;
    end else begin
      if (wr_b) mem[bus.addr_b] <= bus.data_b;
      if (wr_a) mem[bus.addr_a] <= bus.data_a;
    end
  end

  // Cross-port reads always see the pre-write word; only the own port may bypass.
  always_comb begin
    rd_a = mem[bus.addr_a];
    rd_b = mem[bus.addr_b];
    if (RDW_MODE != 0 && bus.we_a) rd_a = bus.data_a;
    if (RDW_MODE != 0 && bus.we_b) rd_b = bus.data_b;
  end

  always_comb begin
    q1_a_d = acc_a ? rd_a : q1_a_q;
    q1_b_d = acc_b ? rd_b : q1_b_q;
    coll_d = wr_a && wr_b && (bus.addr_a == bus.addr_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_a_q <= '0;
      q1_b_q <= '0;
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      q1_a_q <= q1_a_d;
      q1_b_q <= q1_b_d;
      v1_a_q <= acc_a;
      v1_b_q <= acc_b;
      coll_q <= coll_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q2_a_q, q2_a_d, q2_b_q, q2_b_d;
      logic              v2_a_q, v2_b_q;

      always_comb begin
        q2_a_d = v1_a_q ? q1_a_q : q2_a_q;
        q2_b_d = v1_b_q ? q1_b_q : q2_b_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q2_a_q <= '0;
          q2_b_q <= '0;
          v2_a_q <= 1'b0;
          v2_b_q <= 1'b0;
        end else begin
          q2_a_q <= q2_a_d;
          q2_b_q <= q2_b_d;
          v2_a_q <= v1_a_q;
          v2_b_q <= v1_b_q;
        end
      end

      assign bus.q_a     = q2_a_q;
      assign bus.q_b     = q2_b_q;
      assign bus.valid_a = v2_a_q;
      assign bus.valid_b = v2_b_q;
    end else begin : g_noreg
      assign bus.q_a     = q1_a_q;
      assign bus.q_b     = q1_b_q;
      assign bus.valid_a = v1_a_q;
      assign bus.valid_b = v1_b_q;
    end
  endgenerate

  assign bus.init_busy = ~run;
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: four instances covering read-first/write-first and
// with/without output register, checked every cycle against a behavioural model.
module tb_dual_port_ram_p;

  localparam int NC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_a, we_a, en_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;

  logic [7:0] qa [4];
  logic [7:0] qb [4];
  logic       va [4];
  logic       vb [4];
  logic       busy [4];
  logic       coll [4];

  int compared   = 0;
  int mismatched = 0;

  // Instance k: RDW_MODE = k%2, OUT_REG = k/2.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      dual_port_ram_p_if #(.DATA_W(8), .ADDR_W(6)) bus ();
      assign bus.en_a   = en_a;
      assign bus.we_a   = we_a;
      assign bus.addr_a = addr_a;
      assign bus.data_a = data_a;
      assign bus.en_b   = en_b;
      assign bus.we_b   = we_b;
      assign bus.addr_b = addr_b;
      assign bus.data_b = data_b;

      dual_port_ram_p #(
        .DATA_W(8), .ADDR_W(6), .RDW_MODE(g % 2), .OUT_REG(g / 2)
      ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );

      assign qa[g]   = bus.q_a;
      assign qb[g]   = bus.q_b;
      assign va[g]   = bus.valid_a;
      assign vb[g]   = bus.valid_b;
      assign busy[g] = bus.init_busy;
      assign coll[g] = bus.collision;
    end
  endgenerate

  // Behavioural model: word array, clear counter, and a log of every accepted
  // access (indexed by rising-edge number) with its read-first and write-first returns.
  logic [7:0] mem_m [64];
  int         ecnt     = 0;
  int         rmark    = 0;
  int         init_cnt = 0;
  bit         coll_m   = 1'b0;
  bit         rv_a [NC];
  bit         rv_b [NC];
  logic [7:0] rd_a [2][NC];
  logic [7:0] rd_b [2][NC];

  always @(negedge rst_n) begin
    rmark    = ecnt;
    init_cnt = 0;
    coll_m   = 1'b0;
  end

  always @(posedge clk) begin
    if (ecnt < NC - 1) ecnt++;
    rv_a[ecnt] = 1'b0;
    rv_b[ecnt] = 1'b0;
    if (!rst_n) begin
      rmark    = ecnt;
      init_cnt = 0;
      coll_m   = 1'b0;
    end else if (init_cnt < 64) begin
      mem_m[init_cnt] = 8'h00;
      init_cnt++;
      coll_m = 1'b0;
    end else begin
      rv_a[ecnt]    = en_a;
      rd_a[0][ecnt] = mem_m[addr_a];
      rd_a[1][ecnt] = we_a ? data_a : mem_m[addr_a];
      rv_b[ecnt]    = en_b;
      rd_b[0][ecnt] = mem_m[addr_b];
      rd_b[1][ecnt] = we_b ? data_b : mem_m[addr_b];
      coll_m = en_a && we_a && en_b && we_b && (addr_a == addr_b);
      if (en_b && we_b) mem_m[addr_b] = data_b;
      if (en_a && we_a) mem_m[addr_a] = data_a;
    end
  end

  // Expected output after edge ecnt: valid if an access was accepted (L-1) edges
  // earlier; data is the most recent such return since the last reset, else zero.
  task automatic exp_port(input bit side, input int k, output bit v, output logic [7:0] d);
    int  idx;
    bit  found;
    idx   = ecnt - (k / 2);
    v     = 1'b0;
    d     = 8'h00;
    found = 1'b0;
    if (idx > rmark) v = side ? rv_b[idx] : rv_a[idx];
    for (int j = idx; j > rmark; j--) begin
      if (!found && (side ? rv_b[j] : rv_a[j])) begin
        d     = side ? rd_b[k % 2][j] : rd_a[k % 2][j];
        found = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit         v;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      exp_port(1'b0, k, v, d);
      chk("q_a", k, qa[k], d);
      chk("valid_a", k, va[k], v);
      exp_port(1'b1, k, v, d);
      chk("q_b", k, qb[k], d);
      chk("valid_b", k, vb[k], v);
      chk("init_busy", k, busy[k], (init_cnt < 64));
      chk("collision", k, coll[k], coll_m);
    end
  end

  task automatic step(input bit ea, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                      input bit eb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
  endtask

  task automatic count_init(input string nm);
    int n;
    n = 0;
    while (busy[0] === 1'b1 && n < 200) begin
      step(1'b1, 1'b1, 6'h03, 8'hAA, 1'b1, 1'b1, 6'h3F, 8'hBB);
      n++;
    end
    chk(nm, 0, n, 64);
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_q_a"}, k, qa[k], 8'h00);
      chk({nm, "_q_b"}, k, qb[k], 8'h00);
      chk({nm, "_valid_a"}, k, va[k], 1'b0);
      chk({nm, "_valid_b"}, k, vb[k], 1'b0);
      chk({nm, "_collision"}, k, coll[k], 1'b0);
      chk({nm, "_busy"}, k, busy[k], 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Requests issued throughout the clear sequence must be ignored.
    rst_n = 1'b1;
    count_init("init_len");
    step(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h3F, 8'h00);
    chk("rd00", 0, qa[0], 8'h00);
    chk("rd3f", 0, qb[0], 8'h00);
    chk("rd00_v", 0, va[0], 1'b1);

    step(1'b1, 1'b1, 6'h01, 8'h33, 1'b1, 1'b1, 6'h02, 8'h44);
    step(1'b1, 1'b0, 6'h02, 8'h00, 1'b1, 1'b0, 6'h01, 8'h00);
    chk("xrd_a", 0, qa[0], 8'h44);
    chk("xrd_b", 0, qb[0], 8'h33);
    chk("xrd_vb", 0, vb[0], 1'b1);

    step(1'b1, 1'b1, 6'h03, 8'h55, 1'b0, 1'b0, 6'h00, 8'h00);
    chk("rdw_rf", 0, qa[0], 8'h00);
    chk("rdw_wf", 1, qa[1], 8'h55);

    step(1'b1, 1'b1, 6'h05, 8'h77, 1'b1, 1'b1, 6'h05, 8'h88);
    chk("coll_pulse", 0, coll[0], 1'b1);
    chk("coll_qb_rf", 0, qb[0], 8'h00);
    chk("coll_qb_wf", 1, qb[1], 8'h88);
    step(1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    chk("coll_end", 0, coll[0], 1'b0);
    chk("coll_winner", 0, qa[0], 8'h77);

    idle();
    step(1'b1, 1'b0, 6'h01, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    chk("oreg_v1", 2, va[2], 1'b0);
    idle();
    chk("oreg_v2", 2, va[2], 1'b1);
    chk("oreg_q2", 2, qa[2], 8'h33);
    idle();
    chk("oreg_hold_v", 2, va[2], 1'b0);
    chk("oreg_hold_q", 2, qa[2], 8'h33);

    // Mixed traffic over a small address window to exercise overlaps.
    for (int i = 0; i < 120; i++) begin
      step((i % 3) != 0, (i % 4) == 1, 6'((i * 5) % 8), 8'(i * 13),
           (i % 7) != 3, (i % 5) == 2, 6'((i * 3) % 8), 8'(i * 29 + 1));
    end

    // Asynchronous reset in mid-RUN with reads in flight.
    step(1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    #1 chk_zero("run_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("init_rst");
    @(negedge clk);
    rst_n = 1'b1;
    count_init("reinit_len");
    step(1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 6'h01, 8'h00);
    chk("cleared_05", 0, qa[0], 8'h00);
    chk("cleared_01", 0, qb[0], 8'h00);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
